sobel_pipe: RTL

- Pipelined, parametrised Sobel edge operator for the edge-detection datapath. Each accepted beat carries one 3x3 neighbourhood and its centre coordinate; the block emits one filtered pixel per beat.
- Runs entirely on the system clock. Valid/ready handshakes on both sides replace the pixel-clock strobe scheme, so the line buffer upstream and the frame writer downstream can stall independently.
- Adds a programmable threshold, selectable output modes, configurable pixel width and image size, and coordinate pass-through.

---
 rtl/sobel_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sobel_pipe.sv
// Three-stage Sobel edge operator with valid/ready flow control.
// Each beat carries one 3x3 neighbourhood plus its centre coordinate.
module sobel_pipe #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned MAX_ROW    = 480,
  parameter int unsigned MAX_COL    = 640,
  parameter int unsigned ROW_W      = 10,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned BORDER_VAL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  input  logic [8*PIX_W-1:0] in_pixels,
  input  logic [1:0]         mode,
  input  logic [PIX_W+2:0]   threshold,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pix,
  output logic [ROW_W-1:0]   out_row,
  output logic [COL_W-1:0]   out_col
);

  localparam int unsigned SUM_W = PIX_W + 2;
  localparam int unsigned MAG_W = PIX_W + 3;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(MAX_ROW - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(MAX_COL - 1);
  localparam logic [PIX_W-1:0] BORDER_PIX = PIX_W'(BORDER_VAL);
  localparam logic [PIX_W-1:0] PIX_MAX    = '1;
  localparam logic [MAG_W-1:0] MAG_SAT    = MAG_W'(PIX_MAX);

  // Single global enable: every stage moves only when the output slot frees up
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [PIX_W-1:0] tl, t, tr, ml, mr, bl, b, br;
  assign tl = in_pixels[8*PIX_W-1 -: PIX_W];
  assign t  = in_pixels[7*PIX_W-1 -: PIX_W];
  assign tr = in_pixels[6*PIX_W-1 -: PIX_W];
  assign ml = in_pixels[5*PIX_W-1 -: PIX_W];
  assign mr = in_pixels[4*PIX_W-1 -: PIX_W];
  assign bl = in_pixels[3*PIX_W-1 -: PIX_W];
  assign b  = in_pixels[2*PIX_W-1 -: PIX_W];
  assign br = in_pixels[1*PIX_W-1 -: PIX_W];

  logic             s1_valid, s1_edge;
  logic [SUM_W-1:0] s1_px, s1_nx, s1_py, s1_ny;
  logic [1:0]       s1_mode;
  logic [MAG_W-1:0] s1_thr;
  logic [ROW_W-1:0] s1_row;
  logic [COL_W-1:0] s1_col;

  // S1: weighted column/row sums and border flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_edge  <= 1'b0;
      s1_px    <= '0;
      s1_nx    <= '0;
      s1_py    <= '0;
      s1_ny    <= '0;
      s1_mode  <= '0;
      s1_thr   <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_px   <= SUM_W'(tr) + (SUM_W'(mr) << 1) + SUM_W'(br);
        s1_nx   <= SUM_W'(tl) + (SUM_W'(ml) << 1) + SUM_W'(bl);
        s1_py   <= SUM_W'(bl) + (SUM_W'(b)  << 1) + SUM_W'(br);
        s1_ny   <= SUM_W'(tl) + (SUM_W'(t)  << 1) + SUM_W'(tr);
        s1_edge <= (row == '0) | (row == LAST_ROW) | (col == '0) | (col == LAST_COL);
        s1_mode <= mode;
        s1_thr  <= threshold;
        s1_row  <= row;
        s1_col  <= col;
      end
    end
  end

  logic [SUM_W-1:0] gx, gy;
  logic [MAG_W-1:0] mag_c;
  assign gx    = (s1_px >= s1_nx) ? (s1_px - s1_nx) : (s1_nx - s1_px);
  assign gy    = (s1_py >= s1_ny) ? (s1_py - s1_ny) : (s1_ny - s1_py);
  assign mag_c = MAG_W'(gx) + MAG_W'(gy);

  logic             s2_valid, s2_edge;
  logic [MAG_W-1:0] s2_mag, s2_thr;
  logic [1:0]       s2_mode;
  logic [ROW_W-1:0] s2_row;
  logic [COL_W-1:0] s2_col;

  // S2: L1 gradient magnitude
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_edge  <= 1'b0;
      s2_mag   <= '0;
      s2_thr   <= '0;
      s2_mode  <= '0;
      s2_row   <= '0;
      s2_col   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag  <= mag_c;
        s2_edge <= s1_edge;
        s2_thr  <= s1_thr;
        s2_mode <= s1_mode;
        s2_row  <= s1_row;
        s2_col  <= s1_col;
      end
    end
  end

  logic [PIX_W-1:0] pix_c;
  logic             above;
  assign above = s2_mag > s2_thr;

  // S3 output mapping; mode 3 falls through to binary
  always_comb begin
    pix_c = '0;
    if (s2_edge) begin
      pix_c = BORDER_PIX;
    end else begin
      case (s2_mode)
        2'd1:    pix_c = (s2_mag > MAG_SAT) ? PIX_MAX : s2_mag[PIX_W-1:0];
        2'd2:    pix_c = above ? '0 : PIX_MAX;
        default: pix_c = above ? PIX_MAX : '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_pix <= pix_c;
        out_row <= s2_row;
        out_col <= s2_col;
      end
    end
  end

endmodule
